// File: rtl/axis_out_pack_pkg.sv
// Shared constants for axis_out_pack; supplies the default sideband width macro.
// Optional output word counter is enabled with `OUT_PACK_BEAT_CNT_EN.
`ifndef TUSER_WIDTH_LRELU_IN
`define TUSER_WIDTH_LRELU_IN 8
`endif

package axis_out_pack_pkg;

    localparam int OUT_WIDTH_DEFAULT = 256;
    localparam int WORDS_W           = 32;

    // Lane index needs at least one bit even when only one lane exists.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_out_pack_reg.sv
// Enabled register primitive with asynchronous active-low clear.
module axis_out_pack_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/axis_out_pack.sv
// Packs RATIO narrow AXIS beats LSB-first into one wide output word towards DMA.
// Define `OUT_PACK_BEAT_CNT_EN to add the m_words output handshake counter.
module axis_out_pack
    import axis_out_pack_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int UNITS       = 8,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEFAULT,
    parameter int TUSER_WIDTH = `TUSER_WIDTH_LRELU_IN
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [UNITS-1:0][WORD_WIDTH-1:0]  s_data,
    input  logic [TUSER_WIDTH-1:0]            s_user,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [OUT_WIDTH-1:0]              m_data,
    output logic [OUT_WIDTH/8-1:0]            m_keep,
    output logic [TUSER_WIDTH-1:0]            m_user,
    output logic                              m_valid,
    output logic                              m_last,
    input  logic                              m_ready
`ifdef OUT_PACK_BEAT_CNT_EN
    ,
    output logic [WORDS_W-1:0]                m_words
`endif
);

    localparam int IN_W        = UNITS * WORD_WIDTH;
    localparam int RATIO       = OUT_WIDTH / IN_W;
    localparam int IDX_W       = idx_width(RATIO);
    localparam int KEEP_W      = OUT_WIDTH / 8;
    localparam int LANE_KEEP_W = IN_W / 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic                   accept;
    logic                   complete;
    logic                   first_lane;
    logic [OUT_WIDTH-1:0]   merged;

    logic [IDX_W-1:0]       idx_d,     idx_q;
    logic [OUT_WIDTH-1:0]   acc_d,     acc_q;
    logic [TUSER_WIDTH-1:0] user_d,    user_q;
    logic                   user_en;
    logic [OUT_WIDTH-1:0]   m_data_d,  m_data_q;
    logic [KEEP_W-1:0]      m_keep_d,  m_keep_q;
    logic [TUSER_WIDTH-1:0] m_user_d,  m_user_q;
    logic                   m_last_d,  m_last_q;
    logic                   m_valid_d, m_valid_q;

    assign s_ready = ~m_valid_q | m_ready;

    always_comb begin
        accept     = s_valid & s_ready;
        first_lane = (idx_q == '0);
        complete   = accept & (s_last | (idx_q == IDX_LAST));

        merged = acc_q;
        for (int l = 0; l < RATIO; l++) begin
            if (IDX_W'(l) == idx_q) begin
                merged[l*IN_W +: IN_W] = s_data;
            end
        end

        // Only lanes written in this word are exposed; higher lanes read as zero.
        m_data_d = '0;
        m_keep_d = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (l <= int'(idx_q)) begin
                m_data_d[l*IN_W +: IN_W]               = merged[l*IN_W +: IN_W];
                m_keep_d[l*LANE_KEEP_W +: LANE_KEEP_W] = '1;
            end
        end

        acc_d    = complete ? '0 : merged;
        idx_d    = complete ? '0 : idx_q + IDX_W'(1);
        user_d   = s_user;
        user_en  = accept & first_lane;
        m_user_d = first_lane ? s_user : user_q;
        m_last_d = s_last;
        // A completion in the same cycle as an output handshake reloads with no bubble.
        m_valid_d = complete | (m_valid_q & ~m_ready);
    end

    axis_out_pack_reg #(.W(IDX_W)) u_idx_reg (
        .clk(aclk), .rst_n(aresetn), .en(accept), .d(idx_d), .q(idx_q)
    );

    axis_out_pack_reg #(.W(OUT_WIDTH)) u_acc_reg (
        .clk(aclk), .rst_n(aresetn), .en(accept), .d(acc_d), .q(acc_q)
    );

    axis_out_pack_reg #(.W(TUSER_WIDTH)) u_user_reg (
        .clk(aclk), .rst_n(aresetn), .en(user_en), .d(user_d), .q(user_q)
    );

    axis_out_pack_reg #(.W(OUT_WIDTH)) u_m_data_reg (
        .clk(aclk), .rst_n(aresetn), .en(complete), .d(m_data_d), .q(m_data_q)
    );

    axis_out_pack_reg #(.W(KEEP_W)) u_m_keep_reg (
        .clk(aclk), .rst_n(aresetn), .en(complete), .d(m_keep_d), .q(m_keep_q)
    );

    axis_out_pack_reg #(.W(TUSER_WIDTH)) u_m_user_reg (
        .clk(aclk), .rst_n(aresetn), .en(complete), .d(m_user_d), .q(m_user_q)
    );

    axis_out_pack_reg #(.W(1)) u_m_last_reg (
        .clk(aclk), .rst_n(aresetn), .en(complete), .d(m_last_d), .q(m_last_q)
    );

    axis_out_pack_reg #(.W(1)) u_m_valid_reg (
        .clk(aclk), .rst_n(aresetn), .en(1'b1), .d(m_valid_d), .q(m_valid_q)
    );

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_user  = m_user_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

`ifdef OUT_PACK_BEAT_CNT_EN
    logic               hs_out;
    logic [WORDS_W-1:0] words_d, words_q;
    logic               wrap_d,  wrap_q;

    // The handshake after an m_last handshake restarts the count at 1.
    always_comb begin
        hs_out  = m_valid_q & m_ready;
        words_d = wrap_q ? WORDS_W'(1) : words_q + WORDS_W'(1);
        wrap_d  = m_last_q;
    end

    axis_out_pack_reg #(.W(WORDS_W)) u_words_reg (
        .clk(aclk), .rst_n(aresetn), .en(hs_out), .d(words_d), .q(words_q)
    );

    axis_out_pack_reg #(.W(1)) u_wrap_reg (
        .clk(aclk), .rst_n(aresetn), .en(hs_out), .d(wrap_d), .q(wrap_q)
    );

    assign m_words = words_q;
`endif

endmodule
